// File: rtl/fp_addsub_ctrl.sv
// IEEE-754 single add/sub sequencer for the shared 24-bit mantissa adder; latency 4+ADD_WAIT+k (k = 1 + left shifts), specials 2.
// start is sampled only in IDLE and never queued; define FP_ROUND_EN for round-to-nearest (ties away) on the guard bit, else truncate.
module fp_addsub_ctrl #(
    parameter int ADD_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        invalid,
    output logic        add_en,
    output logic [23:0] add_a,
    output logic [23:0] add_b,
    output logic        add_sign_a,
    output logic        add_sign_b,
    output logic        add_sub,
    output logic        add_cin,
    input  logic [23:0] add_sum,
    input  logic        add_cout,
    input  logic        add_sign_s
);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t      state_q;
    logic [31:0] a_q, b_q;
    logic        sub_q;
    logic        sign_q, eff_sub_q, guard_q, cout_q;
    logic [8:0]  exp_q;
    logic [23:0] ma_q, mb_q;
    logic [7:0]  d_q;
    logic [7:0]  cnt_q;

    assign add_sign_a = 1'b0;
    assign add_sub    = 1'b0;
    assign add_cin    = 1'b0;

    // Operand classification and magnitude ordering, evaluated in UNPACK.
    logic [7:0]  ea, eb, big_e, sml_e;
    logic [22:0] fa, fb, big_f, sml_f;
    logic        sa, sb_eff, big_s, swap;
    logic        nan_a, nan_b, inf_a, inf_b, zro_a, zro_b;
    logic        spec_vld, spec_inv, spec_zr;
    logic [31:0] spec_res;

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        sa     = a_q[31];
        sb_eff = b_q[31] ^ sub_q;
        nan_a  = (ea == 8'hFF) && (fa != 23'd0);
        nan_b  = (eb == 8'hFF) && (fb != 23'd0);
        inf_a  = (ea == 8'hFF) && (fa == 23'd0);
        inf_b  = (eb == 8'hFF) && (fb == 23'd0);
        zro_a  = (ea == 8'd0);
        zro_b  = (eb == 8'd0);
        swap   = {eb, fb} > {ea, fa};
        big_e  = swap ? eb : ea;
        big_f  = swap ? fb : fa;
        big_s  = swap ? sb_eff : sa;
        sml_e  = swap ? ea : eb;
        sml_f  = swap ? fa : fb;

        spec_vld = 1'b1;
        spec_inv = 1'b0;
        spec_zr  = 1'b0;
        spec_res = 32'h7FC0_0000;
        if (nan_a || nan_b) begin
            spec_inv = 1'b1;
        end else if (inf_a && inf_b && (sa != sb_eff)) begin
            spec_inv = 1'b1;
        end else if (inf_a) begin
            spec_res = {sa, 8'hFF, 23'd0};
        end else if (inf_b) begin
            spec_res = {sb_eff, 8'hFF, 23'd0};
        end else if (zro_a && zro_b) begin
            spec_res = 32'd0;
            spec_zr  = 1'b1;
        end else if (zro_a) begin
            spec_res = {sb_eff, b_q[30:0]};
        end else if (zro_b) begin
            spec_res = a_q;
        end else begin
            spec_vld = 1'b0;
        end
    end

    // Bit 0 of the shifted value is the guard bit; shifts of 25 or more leave nothing.
    logic [24:0] aligned;
    assign aligned = {mb_q, 1'b0} >> d_q;

    logic [23:0] rnd_m;
    logic [8:0]  rnd_e;
`ifdef FP_ROUND_EN
    logic [24:0] inc;
    always_comb begin
        inc   = {1'b0, ma_q} + {24'd0, guard_q};
        rnd_m = inc[24] ? 24'h80_0000 : inc[23:0];
        rnd_e = exp_q + {8'd0, inc[24]};
    end
`else
    always_comb begin
        rnd_m = ma_q;
        rnd_e = exp_q;
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{add_sign_s, guard_q, rnd_m[23]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            invalid    <= 1'b0;
            add_en     <= 1'b0;
            add_a      <= 24'd0;
            add_b      <= 24'd0;
            add_sign_b <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            sub_q      <= 1'b0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            guard_q    <= 1'b0;
            cout_q     <= 1'b0;
            exp_q      <= 9'd0;
            ma_q       <= 24'd0;
            mb_q       <= 24'd0;
            d_q        <= 8'd0;
            cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        sub_q   <= sub;
                        busy    <= 1'b1;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (spec_vld) begin
                        result   <= spec_res;
                        invalid  <= spec_inv;
                        zero     <= spec_zr;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        sign_q    <= big_s;
                        eff_sub_q <= (sa != sb_eff);
                        exp_q     <= {1'b0, big_e};
                        ma_q      <= {1'b1, big_f};
                        mb_q      <= {1'b1, sml_f};
                        d_q       <= big_e - sml_e;
                        state_q   <= ALIGN;
                    end
                end
                ALIGN: begin
                    add_a      <= ma_q;
                    add_b      <= aligned[24:1];
                    guard_q    <= ~eff_sub_q & aligned[0];
                    add_sign_b <= eff_sub_q;
                    add_en     <= 1'b1;
                    cnt_q      <= 8'd0;
                    state_q    <= ADD;
                end
                ADD: begin
                    if (cnt_q == 8'(ADD_WAIT - 1)) begin
                        ma_q    <= add_sum;
                        cout_q  <= add_cout & ~eff_sub_q;
                        add_en  <= 1'b0;
                        state_q <= NORM;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                NORM: begin
                    if (cout_q) begin
                        ma_q    <= {1'b1, ma_q[23:1]};
                        guard_q <= ma_q[0];
                        exp_q   <= exp_q + 9'd1;
                        cout_q  <= 1'b0;
                        state_q <= ROUND;
                    end else if (ma_q[23]) begin
                        state_q <= ROUND;
                    end else if ((ma_q == 24'd0) || (exp_q <= 9'd1)) begin
                        // Exact cancellation or underflow: flush to +0.
                        result   <= 32'd0;
                        zero     <= 1'b1;
                        invalid  <= 1'b0;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        ma_q  <= {ma_q[22:0], 1'b0};
                        exp_q <= exp_q - 9'd1;
                    end
                end
                ROUND: begin
                    if (rnd_e >= 9'd255) begin
                        result   <= {sign_q, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else begin
                        result   <= {sign_q, rnd_e[7:0], rnd_m[22:0]};
                        overflow <= 1'b0;
                    end
                    zero    <= 1'b0;
                    invalid <= 1'b0;
                    done    <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    add_en  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Scoreboard bench for fp_addsub_ctrl: directed vectors push expected results; a negedge monitor checks each done pulse.
module tb_fp_addsub_ctrl;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done, overflow, zero, invalid;
    logic [31:0] result;
    logic        add_en, add_sign_a, add_sign_b, add_sub, add_cin;
    logic [23:0] add_a, add_b;
    logic [23:0] add_sum;
    logic        add_cout;
    logic        add_sign_s = 1'b0;

    always #5 clk = ~clk;

    fp_addsub_ctrl #(.ADD_WAIT(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .sub(sub),
        .busy(busy), .done(done), .result(result), .overflow(overflow), .zero(zero),
        .invalid(invalid), .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_sign_a(add_sign_a), .add_sign_b(add_sign_b), .add_sub(add_sub),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .add_sign_s(add_sign_s)
    );

    // Mantissa adder: add_a - add_b when add_sign_b, else add_a + add_b with carry out.
    always_comb begin
        if (add_sign_b) begin
            add_cout = 1'b0;
            add_sum  = add_a - add_b;
        end else begin
            {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
        end
    end

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        zr;
        logic        inv;
        int          lat;
        int          en;
        int          t0;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   applied = 0;
    int   miss = 0;
    int   cyc = 0;
    int   en_seen = 0;
    int   vid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    // Monitor: count adder-enable cycles per operation and check every done pulse.
    always @(negedge clk) begin
        if (!busy) en_seen = 0;
        else if (add_en) en_seen++;
        if (done) begin
            if (sbq.size() == 0) begin
                applied++;
                miss++;
                $display("FAIL unexpected_done: got result %08h, expected no done pulse", result);
            end else begin
                me = sbq.pop_front();
                chk($sformatf("v%0d_result", me.id), result, me.res);
                chk($sformatf("v%0d_flags", me.id), {29'd0, overflow, zero, invalid},
                    {29'd0, me.ov, me.zr, me.inv});
                if (me.lat > 0) chk($sformatf("v%0d_latency", me.id), cyc - me.t0, me.lat);
                chk($sformatf("v%0d_add_en_cycles", me.id), en_seen, me.en);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] r, input logic ov, input logic zr, input logic inv,
                         input int lat, input int en, input bit push);
        exp_t e;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        if (push) begin
            e.res = r; e.ov = ov; e.zr = zr; e.inv = inv;
            e.lat = lat; e.en = en; e.t0 = cyc; e.id = vid;
            vid++;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            applied++;
            miss++;
            $display("FAIL timeout_idle: busy=%0b done=%0b after %0d cycles, expected idle", busy, done, n);
        end
    endtask

    task automatic wait_en();
        int n = 0;
        while (!add_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!add_en) begin
            applied++;
            miss++;
            $display("FAIL timeout_add_en: add_en=0 after %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {25'd0, busy, done, overflow, zero, invalid, add_en, add_sign_b}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_add_a", {8'd0, add_a}, 32'd0);
        chk("rst_add_b", {8'd0, add_b}, 32'd0);

        // 1.0 + 2.0
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 0, 0, 0, 7, AW, 1); wait_idle();
        // 3.0 - 1.0, adder must subtract
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 0, 0, 0, 0, AW, 1);
        wait_en();
        chk("sub_add_sign_b", {31'd0, add_sign_b}, 32'd1);
        wait_idle();
        // exact cancellation
        issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 0, 1, 0, 0, AW, 1); wait_idle();
        // max + max overflows
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1, 0, 0, 7, AW, 1); wait_idle();
        // 1.0 + 1.0 carry out
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 0, 0, 0, 7, AW, 1); wait_idle();
        // 1.0 - 0.75: two left shifts
        issue(32'h3F80_0000, 32'h3F40_0000, 1'b1, 32'h3E80_0000, 0, 0, 0, 9, AW, 1); wait_idle();
        // 1.0 - 2.0: swap, negative result, one left shift
        issue(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 0, 0, 0, 8, AW, 1); wait_idle();
        // -1.0 + -1.0
        issue(32'hBF80_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000, 0, 0, 0, 7, AW, 1); wait_idle();
        // 1.0 + 2^-24: shift of 24, only the guard bit survives
`ifdef FP_ROUND_EN
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0001, 0, 0, 0, 7, AW, 1); wait_idle();
`else
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 0, 0, 0, 7, AW, 1); wait_idle();
`endif
        // specials
        issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 0, 0, 1, 2, 0, 1); wait_idle();
        issue(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1, 0, 2, 0, 1); wait_idle();
        issue(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 0, 0, 0, 2, 0, 1); wait_idle();
        issue(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 0, 0, 0, 2, 0, 1); wait_idle();
        issue(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 0, 0, 0, 2, 0, 1); wait_idle();

        // inf - inf, plus a second start while busy that must be dropped
        issue(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 0, 0, 1, 2, 0, 1);
        op_a  = 32'h3F80_0000;
        op_b  = 32'h4000_0000;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);

        // reset in the middle of ADD drops the operation
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0);
        wait_en();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_add_en", {31'd0, add_en}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 0, 0, 0, 7, AW, 1); wait_idle();
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
        $finish;
    end
endmodule
